// File: rtl/debounce_sync_pair.sv
// Two-channel input conditioner: 2-flop synchroniser plus stable-count debouncer per channel.
// Define DEBOUNCE_EDGE_EN to add registered one-cycle rise/fall pulses per channel.
module debounce_sync_pair #(
    parameter  int unsigned STABLE_CYCLES = 4,
    localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Channel index 0 is A, 1 is B; the channels never interact.
    logic [1:0]       raw;
    logic [1:0]       s1_q;
    logic [1:0]       s2_q;
    logic [1:0]       clean_q;
    logic [1:0]       clean_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    assign raw = {b_raw, a_raw};

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        clean_d = clean_q;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = '0;
            if (s2_q[ch] == clean_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                clean_d[ch] = s2_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates make every flop sample pre-edge values, so s1->s2 is a true two-stage pipe.
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            clean_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            clean_q  <= clean_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign a = clean_q[0];
    assign b = clean_q[1];

`ifdef DEBOUNCE_EDGE_EN
    logic [1:0] rise_q;
    logic [1:0] fall_q;

    // Pulses are registered on the same edge the clean level changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= clean_d & ~clean_q;
            fall_q <= ~clean_d & clean_q;
        end
    end

    assign a_rise = rise_q[0];
    assign a_fall = fall_q[0];
    assign b_rise = rise_q[1];
    assign b_fall = fall_q[1];
`endif

endmodule

// File: tb/tb_debounce_sync_pair.sv
// Self-checking bench for debounce_sync_pair: window-based reference model feeding a scoreboard,
// plus directed latency / glitch / reset scenarios. Edge pulses are checked when DEBOUNCE_EDGE_EN is set.
module tb_debounce_sync_pair;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
`ifdef DEBOUNCE_EDGE_EN
    logic a_rise, a_fall, b_rise, b_fall;
`endif

    always #5 clk = ~clk;

    debounce_sync_pair #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b)
`ifdef DEBOUNCE_EDGE_EN
        ,
        .a_rise(a_rise),
        .a_fall(a_fall),
        .b_rise(b_rise),
        .b_fall(b_fall)
`endif
    );

    typedef struct packed {
        logic a;
        logic b;
        logic ar;
        logic af;
        logic br;
        logic bf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   sb_en  = 1'b0;

    // Reference model: the clean level flips when the last S pre-edge values of the
    // two-stage-delayed input all disagree with it.
    logic [1:0]   m_s1 = '0;
    logic [1:0]   m_s2 = '0;
    logic [1:0]   m_q  = '0;
    logic [S-1:0] m_win [2];
    logic [1:0]   m_raw;
    logic [1:0]   m_rise;
    logic [1:0]   m_fall;
    exp_t         m_e;

    initial begin : model
        m_win[0] = '0;
        m_win[1] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            m_rise = '0;
            m_fall = '0;
            if (rst) begin
                m_s1 = '0;
                m_s2 = '0;
                m_q  = '0;
                m_win[0] = '0;
                m_win[1] = '0;
                sb_en = 1'b1;
            end else if (sb_en) begin
                m_raw = {b_raw, a_raw};
                for (int ch = 0; ch < 2; ch++) begin
                    m_win[ch] = {m_win[ch][S-2:0], m_s2[ch]};
                    if (m_win[ch] == {S{~m_q[ch]}}) begin
                        m_q[ch]    = ~m_q[ch];
                        m_rise[ch] = m_q[ch];
                        m_fall[ch] = ~m_q[ch];
                    end
                end
                m_s2 = m_s1;
                m_s1 = m_raw;
            end
            if (sb_en) begin
                m_e.a  = m_q[0];
                m_e.b  = m_q[1];
                m_e.ar = m_rise[0];
                m_e.af = m_fall[0];
                m_e.br = m_rise[1];
                m_e.bf = m_fall[1];
                sb_q.push_back(m_e);
            end
        end
    end

    exp_t c_e;

    initial begin : sb_checker
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                c_e = sb_q.pop_front();
                checks++;
                if ({a, b} !== {c_e.a, c_e.b}) begin
                    errors++;
                    $display("FAIL sb_levels cyc=%0d got a=%b b=%b want a=%b b=%b",
                             cyc, a, b, c_e.a, c_e.b);
                end
`ifdef DEBOUNCE_EDGE_EN
                checks++;
                if ({a_rise, a_fall, b_rise, b_fall} !== {c_e.ar, c_e.af, c_e.br, c_e.bf}) begin
                    errors++;
                    $display("FAIL sb_pulses cyc=%0d got %b%b%b%b want %b%b%b%b", cyc,
                             a_rise, a_fall, b_rise, b_fall, c_e.ar, c_e.af, c_e.br, c_e.bf);
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic wait_out(input int ch, input logic val, input int bound,
                            output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (((ch == 0) ? a : b) === val) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a !== 1'b0 || b !== 1'b0) begin
            errors++;
            $display("FAIL reset_levels got a=%b b=%b want 0 0", a, b);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_step();
        int e, at;
        bit ok;
        a_raw = 1'b1;
        e = cyc + 1;
        wait_out(0, 1'b1, 20, at, ok);
        checks++;
        if (!ok || at - e != S + 1) begin
            errors++;
            $display("FAIL clean_step_latency got %0d want %0d (ok=%0d)", at - e, S + 1, ok);
        end
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL clean_step_b got %b want 0", b);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fall();
        int e, at;
        bit ok;
        a_raw = 1'b0;
        e = cyc + 1;
        wait_out(0, 1'b0, 20, at, ok);
        checks++;
        if (!ok || at - e != S + 1) begin
            errors++;
            $display("FAIL fall_latency got %0d want %0d (ok=%0d)", at - e, S + 1, ok);
        end
`ifdef DEBOUNCE_EDGE_EN
        checks++;
        if (a_fall !== 1'b1 || a_rise !== 1'b0) begin
            errors++;
            $display("FAIL fall_pulse got fall=%b rise=%b want 1 0", a_fall, a_rise);
        end
        @(negedge clk);
        checks++;
        if (a_fall !== 1'b0) begin
            errors++;
            $display("FAIL fall_pulse_width got fall=%b want 0", a_fall);
        end
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bounce();
        logic pat [5];
        int   last, at, bad;
        bit   ok;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        last = 0;
        for (int i = 0; i < 5; i++) begin
            a_raw = pat[i];
            if (pat[i]) last = cyc + 1;
            if (i < 4) @(negedge clk);
        end
        wait_out(0, 1'b1, 30, at, ok);
        checks++;
        if (!ok || at - last != S + 1) begin
            errors++;
            $display("FAIL bounce_latency got %0d want %0d (ok=%0d)", at - last, S + 1, ok);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_hold got %0d low cycles want 0", bad);
        end
        a_raw = 1'b0;
        wait_out(0, 1'b0, 20, at, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bounce_release got a=%b want 0", a);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_short_glitch();
        int highs;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            b_raw = (i < 3);
            @(negedge clk);
            if (b !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL glitch3_reject got %0d high cycles want 0", highs);
        end
        highs = 0;
        for (int i = 0; i < 25; i++) begin
            b_raw = (i < 4);
            @(negedge clk);
            if (b === 1'b1) highs++;
        end
        checks++;
        if (highs != 4) begin
            errors++;
            $display("FAIL pulse4_width got %0d high cycles want 4", highs);
        end
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL pulse4_return got b=%b want 0", b);
        end
    endtask

    task automatic test_simultaneous();
        int   e, ra, rb, glitches;
        logic c, c_prev;
        a_raw = 1'b1;
        b_raw = 1'b1;
        e = cyc + 1;
        ra = -1;
        rb = -1;
        glitches = 0;
        c_prev = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a === 1'b1 && ra < 0) ra = cyc;
            if (b === 1'b1 && rb < 0) rb = cyc;
            c = a | b;
            if (c_prev && !c) glitches++;
            c_prev = c;
        end
        checks++;
        if (ra != rb || ra - e != S + 1) begin
            errors++;
            $display("FAIL simul_rise got a@%0d b@%0d want both @%0d", ra - e, rb - e, S + 1);
        end
        checks++;
        if (glitches != 0) begin
            errors++;
            $display("FAIL simul_or_glitch got %0d drops want 0", glitches);
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (a !== 1'b0 || b !== 1'b0) begin
            errors++;
            $display("FAIL simul_release got a=%b b=%b want 0 0", a, b);
        end
    endtask

    task automatic test_reset_mid();
        int r, at;
        bit ok;
        a_raw = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_level got a=%b want 0", a);
        end
        @(negedge clk);
        rst = 1'b0;
        r = cyc + 1;
        wait_out(0, 1'b1, 20, at, ok);
        checks++;
        if (!ok || at - r != S + 1) begin
            errors++;
            $display("FAIL reset_mid_latency got %0d want %0d (ok=%0d)", at - r, S + 1, ok);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int ha, hb;
        ha = 0;
        hb = 0;
        for (int i = 0; i < 400; i++) begin
            if (ha == 0) begin
                a_raw = 1'($urandom_range(0, 1));
                ha = $urandom_range(1, 7);
            end
            if (hb == 0) begin
                b_raw = 1'($urandom_range(0, 1));
                hb = $urandom_range(1, 7);
            end
            ha--;
            hb--;
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin : main
        test_reset();
        test_clean_step();
        test_fall();
        test_bounce();
        test_short_glitch();
        test_simultaneous();
        test_reset_mid();
        test_fall();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
